// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo buffer.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_PAR   = 3'd3,
    R_STOP  = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_START = 3'd1,
    T_DATA  = 3'd2,
    T_PAR   = 3'd3,
    T_STOP  = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_START = 3'd1,
    T_DATA  = 3'd2,
    T_STOP  = 3'd4
  } tx_state_t;
`endif

  // Parity bit for a payload zero-extended to 8 bits; odd=1 makes the total count of ones odd.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_echo_buf_if.sv
// Push/pop handshake bundle between the UART core and its echo FIFO.
interface uart_echo_buf_if #(
  parameter int WIDTH = 8,
  parameter int LW    = 5
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;

  modport master (output push, pop, din, input dout, full, empty, level);
  modport slave  (input push, pop, din, output dout, full, empty, level);
endinterface

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; push while full is accepted only together with a pop.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_echo_buf_if.slave   f
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push_s, do_pop_s;

  // Qualify requests: never pop empty, push into a full FIFO only when a pop frees a slot.
  always_comb begin
    do_pop_s  = f.pop && (level_q != LW'(0));
    do_push_s = f.push && ((level_q != LW'(DEPTH)) || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= f.din;
    end
  end

  assign f.dout  = mem_q[rd_ptr_q];
  assign f.full  = (level_q == LW'(DEPTH));
  assign f.empty = (level_q == LW'(0));
  assign f.level = level_q;

endmodule

// File: rtl/uart_echo_buf.sv
// UART receiver that buffers good frames in a FIFO and retransmits them on tx.
// Optional feature macro: UART_PARITY_EN adds a parity bit (PARITY_ODD selects odd).
module uart_echo_buf #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk50,
  input  logic                        reset,
  input  logic                        rx,
  output logic                        tx,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  import uart_pkg::*;

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0]        div_q, div_d;
  logic                 tick_s;
  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;

  rx_state_t            rx_state_q;
  logic [3:0]           rx_tcnt_q;
  logic [2:0]           rx_bcnt_q;
  logic [DATA_BITS-1:0] rx_shreg_q;
  logic                 push_q;
  logic                 frame_err_q;
  logic                 mid_s;
  logic                 ovf_q, ovf_d;

  tx_state_t            tx_state_q;
  logic [3:0]           tx_tcnt_q;
  logic [2:0]           tx_bcnt_q;
  logic [DATA_BITS-1:0] tx_shreg_q;
  logic                 tx_q;
  logic                 bit_end_s;
  logic                 pop_s;

`ifdef UART_PARITY_EN
  logic                 rx_par_q;
  logic                 parity_err_q;
  logic                 tx_par_q;
  logic                 par_bad_s;
`endif

  uart_echo_buf_if #(.WIDTH(DATA_BITS), .LW(LW)) fifo_bus ();

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk50),
    .reset (reset),
    .f     (fifo_bus)
  );

  // Oversample divider wraps at DIV-1; input synchroniser shifts in rx.
  always_comb begin
    tick_s = (div_q == DW'(DIV - 1));
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    sync_d = {sync_q[0], rx};
  end

  // Divider and two-flop synchroniser (idle-high).
  always_ff @(posedge clk50) begin
    if (reset) begin
      div_q  <= '0;
      sync_q <= 2'b11;
    end else begin
      div_q  <= div_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s  = sync_q[1];
  assign mid_s = tick_s && (rx_tcnt_q == 4'(MID_SAMPLE));

`ifdef UART_PARITY_EN
  assign par_bad_s = (rx_par_q != calc_parity(8'(rx_shreg_q), PARITY_ODD[0]));
`endif

  // Receiver FSM: rx_tcnt free-runs on ticks so every later sample lands 16 ticks after the previous one.
  always_ff @(posedge clk50) begin
    if (reset) begin
      rx_state_q   <= R_IDLE;
      rx_tcnt_q    <= 4'd0;
      rx_bcnt_q    <= 3'd0;
      rx_shreg_q   <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (tick_s) begin
        rx_tcnt_q <= rx_tcnt_q + 4'd1;
      end
      case (rx_state_q)
        R_IDLE: begin
          if (!rx_s) begin
            rx_state_q <= R_START;
            rx_tcnt_q  <= 4'd0;
          end
        end
        R_START: begin
          if (mid_s) begin
            rx_bcnt_q  <= 3'd0;
            rx_state_q <= rx_s ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (mid_s) begin
            rx_shreg_q <= {rx_s, rx_shreg_q[DATA_BITS-1:1]};
            rx_bcnt_q  <= rx_bcnt_q + 3'd1;
            if (rx_bcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_q <= R_PAR;
`else
              rx_state_q <= R_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        R_PAR: begin
          if (mid_s) begin
            rx_par_q   <= rx_s;
            rx_state_q <= R_STOP;
          end
        end
`endif
        R_STOP: begin
          if (mid_s) begin
            rx_state_q  <= R_IDLE;
            frame_err_q <= !rx_s;
`ifdef UART_PARITY_EN
            parity_err_q <= par_bad_s;
            push_q       <= rx_s && !par_bad_s;
`else
            push_q       <= rx_s;
`endif
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // Pop at a tick boundary when idle, or at the end of a stop bit for gap-free back-to-back frames.
  always_comb begin
    bit_end_s = tick_s && (tx_tcnt_q == 4'd15);
    pop_s     = tick_s && !fifo_bus.empty &&
                ((tx_state_q == T_IDLE) || ((tx_state_q == T_STOP) && (tx_tcnt_q == 4'd15)));
    ovf_d     = push_q && fifo_bus.full && !pop_s;
  end

  // Transmitter FSM: every bit spans 16 ticks counted by tx_tcnt.
  always_ff @(posedge clk50) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      tx_tcnt_q  <= 4'd0;
      tx_bcnt_q  <= 3'd0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tick_s) begin
        tx_tcnt_q <= tx_tcnt_q + 4'd1;
      end
      case (tx_state_q)
        T_IDLE: begin
          if (pop_s) begin
            tx_state_q <= T_START;
            tx_tcnt_q  <= 4'd0;
            tx_shreg_q <= fifo_bus.dout;
            tx_q       <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= calc_parity(8'(fifo_bus.dout), PARITY_ODD[0]);
`endif
          end
        end
        T_START: begin
          if (bit_end_s) begin
            tx_state_q <= T_DATA;
            tx_bcnt_q  <= 3'd0;
            tx_q       <= tx_shreg_q[0];
          end
        end
        T_DATA: begin
          if (bit_end_s) begin
            if (tx_bcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_q <= T_PAR;
              tx_q       <= tx_par_q;
`else
              tx_state_q <= T_STOP;
              tx_q       <= 1'b1;
`endif
            end else begin
              tx_bcnt_q  <= tx_bcnt_q + 3'd1;
              tx_shreg_q <= {1'b0, tx_shreg_q[DATA_BITS-1:1]};
              tx_q       <= tx_shreg_q[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        T_PAR: begin
          if (bit_end_s) begin
            tx_state_q <= T_STOP;
            tx_q       <= 1'b1;
          end
        end
`endif
        T_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              tx_state_q <= T_START;
              tx_shreg_q <= fifo_bus.dout;
              tx_q       <= 1'b0;
`ifdef UART_PARITY_EN
              tx_par_q   <= calc_parity(8'(fifo_bus.dout), PARITY_ODD[0]);
`endif
            end else begin
              tx_state_q <= T_IDLE;
              tx_q       <= 1'b1;
            end
          end
        end
        default: begin
          tx_state_q <= T_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  // Overflow pulse for a good frame that found the FIFO full with no pop.
  always_ff @(posedge clk50) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign fifo_bus.push = push_q;
  assign fifo_bus.pop  = pop_s;
  assign fifo_bus.din  = rx_shreg_q;

  assign tx          = tx_q;
  assign frame_err   = frame_err_q;
  assign rx_overflow = ovf_q;
  assign fifo_level  = fifo_bus.level;
`ifdef UART_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_echo_buf.sv
// Scoreboard bench for uart_echo_buf at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_echo_buf;
  import uart_pkg::*;

  localparam int BIT      = 432;
  localparam int HALF     = 216;
  localparam int FAST_BIT = 428;
`ifdef UART_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int STOP_IDX = 9 + PAR_EN;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       tx, frame_err, parity_err, rx_overflow;
  logic [2:0] fifo_level;

  always #10 clk50 = ~clk50;

  uart_echo_buf #(
    .CLK_HZ(50000000), .BAUD(115200), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_ODD(1)
  ) dut (
    .clk50(clk50), .reset(reset), .rx(rx), .tx(tx),
    .frame_err(frame_err), .parity_err(parity_err), .rx_overflow(rx_overflow),
    .fifo_level(fifo_level)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, tx_low_cnt = 0, max_level = 0;
  int rx_stop_cyc = 0, tx_start_cyc = 0;
  bit m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected echo word {parity, data}; odd parity in the parity build, 0 otherwise.
  function automatic logic [8:0] exp_word(input logic [7:0] d);
    logic p;
    p = (PAR_EN != 0) ? ((^d) ^ 1'b1) : 1'b0;
    return {p, d};
  endfunction

  always @(posedge clk50) cyc <= cyc + 1;

  // Pulse counters and level tracking.
  initial begin : pulse_mon
    forever begin
      @(negedge clk50);
      if (frame_err === 1'b1) fe_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (rx_overflow === 1'b1) ov_cnt++;
      if (tx === 1'b0) tx_low_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  // Serial decoder on tx; each completed frame is compared against the scoreboard queue.
  initial begin : tx_mon
    int cnt;
    int idx;
    logic [8:0] word;
    logic [8:0] expv;
    cnt = 0;
    word = 9'd0;
    forever begin
      @(negedge clk50);
      if (reset) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (tx === 1'b0) begin
          m_busy = 1'b1;
          cnt = 0;
          word = 9'd0;
          tx_start_cyc = cyc;
        end
      end else begin
        cnt++;
        if ((cnt % BIT) == HALF) begin
          idx = cnt / BIT;
          if (idx == 0) begin
            if (tx !== 1'b0) m_busy = 1'b0;
          end else if (idx <= 8) begin
            word[idx-1] = tx;
          end else if (idx == STOP_IDX) begin
            check("tx_stop_bit", {31'd0, tx}, 32'd1);
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL tx_unexpected: got 0x%0h expected no frame", word);
            end else begin
              expv = exp_q.pop_front();
              check("tx_byte", {23'd0, word}, {23'd0, expv});
            end
            m_busy = 1'b0;
          end else begin
            word[8] = tx;
          end
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic send_bit(input logic b, input int len);
    rx = b;
    wait_clks(len);
  endtask

  task automatic send_frame(input logic [7:0] d, input int len, input logic par, input logic stop);
    send_bit(1'b0, len);
    for (int i = 0; i < 8; i++) send_bit(d[i], len);
    if (PAR_EN != 0) send_bit(par, len);
    rx_stop_cyc = cyc;
    send_bit(stop, len);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || m_busy) && (n < budget)) begin
      @(negedge clk50);
      n++;
    end
    check({name, "_drained"}, {31'd0, (exp_q.size() == 0) && !m_busy}, 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int fe0, pe0, ov0, tl0, n;
    logic [7:0] burst [6];
    logic [8:0] w;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h5A; burst[5] = 8'hA5;

    // Reset state
    reset = 1'b1;
    rx = 1'b1;
    wait_clks(5);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    reset = 1'b0;
    wait_clks(50);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Scenario 1: single 0x55 echo
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    w = exp_word(8'h55);
    exp_q.push_back(w);
    send_frame(8'h55, BIT, w[8], 1'b1);
    wait_drain("s1", 8000);
    check("s1_latency", {31'd0, ((tx_start_cyc - rx_stop_cyc) > 0) && ((tx_start_cyc - rx_stop_cyc) <= 2 * BIT)}, 32'd1);
    check("s1_frame_err", fe_cnt - fe0, 32'd0);
    check("s1_parity_err", pe_cnt - pe0, 32'd0);
    check("s1_overflow", ov_cnt - ov0, 32'd0);

`ifdef UART_PARITY_EN
    // Scenario 2: odd parity, 0xA3 has four ones so its parity bit is 1
    exp_q.push_back(9'h1A3);
    send_frame(8'hA3, BIT, 1'b1, 1'b1);
    wait_drain("s2_good", 8000);
    fe0 = fe_cnt; pe0 = pe_cnt; tl0 = tx_low_cnt;
    send_frame(8'hA3, BIT, 1'b0, 1'b1);
    wait_clks(1500);
    check("s2_parity_err", pe_cnt - pe0, 32'd1);
    check("s2_frame_err", fe_cnt - fe0, 32'd0);
    check("s2_no_echo", tx_low_cnt - tl0, 32'd0);
    check("s2_level", {29'd0, fifo_level}, 32'd0);
`endif

    // Scenario 3: stop bit forced low
    fe0 = fe_cnt; pe0 = pe_cnt; tl0 = tx_low_cnt;
    w = exp_word(8'h3C);
    send_frame(8'h3C, BIT, w[8], 1'b0);
    wait_clks(1500);
    check("s3_frame_err", fe_cnt - fe0, 32'd1);
    check("s3_parity_err", pe_cnt - pe0, 32'd0);
    check("s3_level", {29'd0, fifo_level}, 32'd0);
    check("s3_tx_high", tx_low_cnt - tl0, 32'd0);

    // Scenario 4: six back-to-back frames 1% fast; the echo drains nearly as fast as frames arrive
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 6; i++) begin
      w = exp_word(burst[i]);
      exp_q.push_back(w);
      send_frame(burst[i], FAST_BIT, w[8], 1'b1);
    end
    wait_drain("s4", 20000);
    check("s4_level_bound", {31'd0, max_level <= 4}, 32'd1);
    check("s4_level_used", {31'd0, max_level >= 1}, 32'd1);
    check("s4_overflow", ov_cnt - ov0, 32'd0);
    check("s4_frame_err", fe_cnt - fe0, 32'd0);
    check("s4_level_end", {29'd0, fifo_level}, 32'd0);

    // Scenario 5: reset during data bit 3 of the 0xF0 echo
    w = exp_word(8'hF0);
    send_frame(8'hF0, BIT, w[8], 1'b1);
    n = 0;
    while ((tx !== 1'b0) && (n < 3000)) begin
      @(negedge clk50);
      n++;
    end
    check("s5_tx_started", {31'd0, tx === 1'b0}, 32'd1);
    wait_clks(4 * BIT + 100);
    check("s5_bit3_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    wait_clks(1);
    check("s5_tx_after_reset", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    check("s5_level_after_reset", {29'd0, fifo_level}, 32'd0);
    wait_clks(100);
    w = exp_word(8'h81);
    exp_q.push_back(w);
    send_frame(8'h81, BIT, w[8], 1'b1);
    wait_drain("s5", 8000);

    // Scenario 6: 5-clock low glitch on rx
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; tl0 = tx_low_cnt;
    rx = 1'b0;
    wait_clks(5);
    rx = 1'b1;
    wait_clks(400);
    check("s6_rx_idle", {31'd0, dut.rx_state_q == R_IDLE}, 32'd1);
    check("s6_frame_err", fe_cnt - fe0, 32'd0);
    check("s6_parity_err", pe_cnt - pe0, 32'd0);
    wait_clks(600);
    check("s6_level", {29'd0, fifo_level}, 32'd0);
    check("s6_no_echo", tx_low_cnt - tl0, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
